// File: rtl/dm_lsu.sv
// Data-memory load/store unit: word-organised RAM with byte/halfword lane steering, load extension
// and a sticky fault record. Optional access counters are enabled by defining DM_ACCESS_CNT_EN.
module dm_lsu #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic [3:0]  ls,
    output logic [31:0] readdata,
    output logic        err,
    output logic [31:0] fault_addr,
    input  logic        err_clr
`ifdef DM_ACCESS_CNT_EN
    ,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic [31:0]   rword;
    logic          is_byte, is_half, is_word;
    logic          aligned, legal, fault;
    logic          ld_ok, st_ok;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic          unused_addr_bits;

    // Bits above the word index only alias; they are deliberately ignored.
    assign unused_addr_bits = ^addr[31:AW+2];

    assign widx  = addr[AW+1:2];
    assign rword = mem[widx];

    assign is_byte = (ls[2:0] == 3'b001);
    assign is_half = (ls[2:0] == 3'b010);
    assign is_word = (ls[2:0] == 3'b100);

    assign aligned = is_byte | (is_half & ~addr[0]) | (is_word & (addr[1:0] == 2'b00));
    assign legal   = (MemRead ^ MemWrite) & aligned;
    assign fault   = (MemRead | MemWrite) & ~legal;
    assign ld_ok   = legal & MemRead;
    assign st_ok   = legal & MemWrite;

    // Store lane steering: replicate the right-aligned data and enable only the addressed lanes.
    always_comb begin
        be    = 4'b0000;
        wdata = writedata;
        if (st_ok) begin
            if (is_byte) begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{writedata[7:0]}};
            end else if (is_half) begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{writedata[15:0]}};
            end else begin
                be    = 4'b1111;
            end
        end
    end

    // Load lane select and extension.
    always_comb begin
        rbyte    = 8'h00;
        rhalf    = addr[1] ? rword[31:16] : rword[15:0];
        readdata = 32'h0;
        case (addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        if (ld_ok) begin
            if (is_byte)
                readdata = {{24{rbyte[7] & ~ls[3]}}, rbyte};
            else if (is_half)
                readdata = {{16{rhalf[15] & ~ls[3]}}, rhalf};
            else
                readdata = rword;
        end
    end

    // NOTE: the RAM array has no reset branch so it maps onto block RAM; gating writes with rst
    // drops a store whose cycle is cut short by an asynchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // A fault in the same cycle as err_clr wins and records the new address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err        <= 1'b0;
            fault_addr <= 32'h0;
        end else if (fault) begin
            err <= 1'b1;
            if (!err || err_clr)
                fault_addr <= addr;
        end else if (err_clr) begin
            err        <= 1'b0;
            fault_addr <= 32'h0;
        end
    end

`ifdef DM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt <= 32'h0;
            st_cnt <= 32'h0;
        end else begin
            if (ld_ok && (ld_cnt != 32'hFFFF_FFFF))
                ld_cnt <= ld_cnt + 32'd1;
            if (st_ok && (st_cnt != 32'hFFFF_FFFF))
                st_cnt <= st_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed scenarios plus randomized traffic against a byte-array
// reference model. Counter checks are compiled in when DM_ACCESS_CNT_EN is defined.
module tb_dm_lsu;

    localparam int DEPTH = 128;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [3:0]  ls;
    logic [31:0] readdata;
    logic        err;
    logic [31:0] fault_addr;
    logic        err_clr;
`ifdef DM_ACCESS_CNT_EN
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
`endif

    dm_lsu #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .addr       (addr),
        .writedata  (writedata),
        .ls         (ls),
        .readdata   (readdata),
        .err        (err),
        .fault_addr (fault_addr),
        .err_clr    (err_clr)
`ifdef DM_ACCESS_CNT_EN
        ,
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mbytes [NBYTES];
    logic        m_err;
    logic [31:0] m_fa;
    logic [31:0] m_ld;
    logic [31:0] m_st;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [3:0] LB  = 4'b0001;
    localparam logic [3:0] LBU = 4'b1001;
    localparam logic [3:0] LH  = 4'b0010;
    localparam logic [3:0] LHU = 4'b1010;
    localparam logic [3:0] LW  = 4'b0100;

    function automatic int unsigned m_size(input logic [3:0] l);
        if (l[0])      return 1;
        else if (l[1]) return 2;
        else           return 4;
    endfunction

    function automatic logic m_legal(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [3:0] l);
        if ($countones(l[2:0]) != 1) return 1'b0;
        if (rd == wr) return 1'b0;
        return (a % m_size(l)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic rd, input logic wr, input logic [31:0] a,
                                           input logic [3:0] l);
        int unsigned idx;
        int unsigned sz;
        logic [31:0] v;
        if (!(rd && m_legal(rd, wr, a, l))) return 32'h0;
        idx = a % NBYTES;
        sz  = m_size(l);
        v   = 32'h0;
        for (int i = 0; i < int'(sz); i++)
            v = v | (32'(mbytes[idx + i]) << (8 * i));
        if (sz < 4 && !l[3] && v[8*sz-1])
            v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // One request cycle: drive after the falling edge, sample readdata before the rising edge,
    // then advance the model and leave the bus idle.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] l, input logic clr,
                         output logic [31:0] got, output logic [31:0] exp);
        logic flt;
        logic lg;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; addr = a; writedata = wd; ls = l; err_clr = clr;
        #1;
        got = readdata;
        exp = m_load(rd, wr, a, l);
        lg  = m_legal(rd, wr, a, l);
        flt = (rd || wr) && !lg;
        @(posedge clk);
        #1;
        if (flt) begin
            if (!m_err || clr) m_fa = a;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
            m_fa  = 32'h0;
        end
        if (lg && wr) begin
            for (int i = 0; i < int'(m_size(l)); i++)
                mbytes[(a % NBYTES) + i] = wd[8*i +: 8];
            if (m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
        end
        if (lg && rd && m_ld != 32'hFFFF_FFFF) m_ld = m_ld + 1;
        MemRead = 0; MemWrite = 0; addr = 0; writedata = 0; ls = 0; err_clr = 0;
    endtask

    task automatic test_reset;
        rst = 1'b0; MemRead = 0; MemWrite = 0; addr = 0; writedata = 0; ls = 0; err_clr = 0;
        m_err = 0; m_fa = 0; m_ld = 0; m_st = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        n_vec++;
        if (fault_addr !== 32'h0) begin n_bad++; $display("FAIL reset_fa got=%h exp=0", fault_addr); end
`ifdef DM_ACCESS_CNT_EN
        n_vec++;
        if (ld_cnt !== 0 || st_cnt !== 0) begin
            n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ld_cnt, st_cnt);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_fill;
        logic [31:0] g, e;
        for (int w = 0; w < DEPTH; w++)
            drive(0, 1, 32'(4 * w), $urandom, LW, 0, g, e);
        for (int w = 0; w < DEPTH; w += 17) begin
            drive(1, 0, 32'(4 * w), 0, LW, 0, g, e);
            n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL fill_rd w=%0d got=%h exp=%h", w, g, e); end
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] g, e;
        drive(0, 1, 32'h10, 32'h8765_4321, LW, 0, g, e);
        drive(1, 0, 32'h11, 0, LB, 0, g, e);
        n_vec++;
        if (g !== 32'h0000_0043) begin n_bad++; $display("FAIL lb_11 got=%h exp=00000043", g); end
        drive(1, 0, 32'h13, 0, LB, 0, g, e);
        n_vec++;
        if (g !== 32'hFFFF_FF87) begin n_bad++; $display("FAIL lb_13 got=%h exp=ffffff87", g); end
        drive(1, 0, 32'h12, 0, LHU, 0, g, e);
        n_vec++;
        if (g !== 32'h0000_8765) begin n_bad++; $display("FAIL lhu_12 got=%h exp=00008765", g); end
        drive(1, 0, 32'h10, 0, LH, 0, g, e);
        n_vec++;
        if (g !== 32'h0000_4321) begin n_bad++; $display("FAIL lh_10 got=%h exp=00004321", g); end
        drive(1, 0, 32'h13, 0, LBU, 0, g, e);
        n_vec++;
        if (g !== 32'h0000_0087) begin n_bad++; $display("FAIL lbu_13 got=%h exp=00000087", g); end
    endtask

    task automatic test_byte_merge;
        logic [31:0] g, e;
        drive(0, 1, 32'h0, 32'h0, LW, 0, g, e);
        drive(0, 1, 32'h2, 32'h1234_56AA, LB, 0, g, e);
        drive(1, 0, 32'h0, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'h00AA_0000) begin n_bad++; $display("FAIL byte_merge got=%h exp=00aa0000", g); end
        drive(0, 1, 32'h2, 32'hBEEF_C0DE, LH, 0, g, e);
        drive(1, 0, 32'h0, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'hC0DE_0000) begin n_bad++; $display("FAIL half_merge got=%h exp=c0de0000", g); end
    endtask

    task automatic test_misaligned;
        logic [31:0] g, e;
        drive(0, 0, 0, 0, 0, 1, g, e);
        drive(0, 1, 32'h4, 32'h1122_3344, LW, 0, g, e);
        drive(0, 1, 32'h6, 32'hDEAD_BEEF, LW, 0, g, e);
        n_vec++;
        if (err !== 1'b1 || fault_addr !== 32'h6) begin
            n_bad++; $display("FAIL misalign_rec got=%b/%h exp=1/00000006", err, fault_addr);
        end
        drive(1, 0, 32'h4, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'h1122_3344) begin n_bad++; $display("FAIL misalign_nowrite got=%h exp=11223344", g); end
        drive(1, 0, 32'h9, 0, LH, 0, g, e);
        n_vec++;
        if (g !== 32'h0) begin n_bad++; $display("FAIL fault_rd0 got=%h exp=0", g); end
        n_vec++;
        if (err !== 1'b1 || fault_addr !== 32'h6) begin
            n_bad++; $display("FAIL second_fault got=%b/%h exp=1/00000006", err, fault_addr);
        end
    endtask

    task automatic test_clear_collision;
        logic [31:0] g, e;
        drive(1, 0, 32'h21, 0, LH, 1, g, e);
        n_vec++;
        if (err !== 1'b1 || fault_addr !== 32'h21) begin
            n_bad++; $display("FAIL clr_collide got=%b/%h exp=1/00000021", err, fault_addr);
        end
        drive(0, 0, 0, 0, 0, 1, g, e);
        n_vec++;
        if (err !== 1'b0 || fault_addr !== 32'h0) begin
            n_bad++; $display("FAIL clr_alone got=%b/%h exp=0/0", err, fault_addr);
        end
    endtask

    task automatic test_alias_illegal;
        logic [31:0] g, e;
        drive(0, 1, 32'h200, 32'hA5A5_5A5A, LW, 0, g, e);
        drive(1, 0, 32'h0, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL alias got=%h exp=a5a55a5a", g); end
        drive(1, 0, 32'h0, 0, 4'b0011, 0, g, e);
        n_vec++;
        if (g !== 32'h0 || err !== 1'b1 || fault_addr !== 32'h0) begin
            n_bad++; $display("FAIL illegal_ls got=%h/%b/%h exp=0/1/0", g, err, fault_addr);
        end
        drive(1, 1, 32'h8, 0, LW, 1, g, e);
        n_vec++;
        if (g !== 32'h0 || err !== 1'b1 || fault_addr !== 32'h8) begin
            n_bad++; $display("FAIL rd_wr_both got=%h/%b/%h exp=0/1/8", g, err, fault_addr);
        end
        drive(0, 0, 32'h44, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'h0 || fault_addr !== 32'h8) begin
            n_bad++; $display("FAIL idle got=%h/%h exp=0/8", g, fault_addr);
        end
    endtask

    task automatic test_random;
        logic [31:0] g, e, a;
        logic [3:0]  l;
        logic        rd, wr;
        int          op;
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 9);
            rd = (op >= 1 && op <= 4) || op == 9;
            wr = (op >= 5 && op <= 8) || op == 9;
            case ($urandom_range(0, 9))
                0:       l = 4'($urandom);
                1, 2, 3: l = {1'($urandom), 3'b001};
                4, 5, 6: l = {1'($urandom), 3'b010};
                default: l = {1'($urandom), 3'b100};
            endcase
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
            drive(rd, wr, a, $urandom, l, ($urandom_range(0, 9) == 0), g, e);
            n_vec++;
            if (g !== e) begin
                n_bad++; $display("FAIL rand_rd n=%0d a=%h ls=%b got=%h exp=%h", n, a, l, g, e);
            end
            n_vec++;
            if (err !== m_err || fault_addr !== m_fa) begin
                n_bad++;
                $display("FAIL rand_err n=%0d got=%b/%h exp=%b/%h", n, err, fault_addr, m_err, m_fa);
            end
`ifdef DM_ACCESS_CNT_EN
            n_vec++;
            if (ld_cnt !== m_ld || st_cnt !== m_st) begin
                n_bad++;
                $display("FAIL rand_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, ld_cnt, st_cnt, m_ld, m_st);
            end
`endif
        end
    endtask

    task automatic test_midcycle_reset;
        logic [31:0] g, e;
        drive(0, 1, 32'h30, 32'h0BAD_F00D, LW, 0, g, e);
        drive(0, 1, 32'h31, 0, LW, 0, g, e);
        @(negedge clk);
        MemWrite = 1; addr = 32'h30; writedata = 32'hFFFF_0000; ls = LW;
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (err !== 1'b0 || fault_addr !== 32'h0) begin
            n_bad++; $display("FAIL async_rst got=%b/%h exp=0/0", err, fault_addr);
        end
        @(posedge clk);
        #1;
        MemWrite = 0; addr = 0; writedata = 0; ls = 0;
        m_err = 0; m_fa = 0; m_ld = 0; m_st = 0;
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 32'h30, 0, LW, 0, g, e);
        n_vec++;
        if (g !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rst_drop_store got=%h exp=0badf00d", g); end
    endtask

`ifdef DM_ACCESS_CNT_EN
    task automatic test_counters;
        logic [31:0] g, e;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        drive(1, 0, 32'h0, 0, LW, 0, g, e);
        drive(0, 1, 32'h4, 32'h1, LW, 0, g, e);
        drive(1, 0, 32'h5, 0, LB, 0, g, e);
        drive(0, 1, 32'h3, 0, LW, 0, g, e);
        drive(0, 1, 32'h6, 32'h2, LH, 0, g, e);
        drive(1, 0, 32'h6, 0, LHU, 0, g, e);
        n_vec++;
        if (ld_cnt !== 32'd3 || st_cnt !== 32'd2) begin
            n_bad++; $display("FAIL cnt got=%0d/%0d exp=3/2", ld_cnt, st_cnt);
        end
        @(negedge clk);
        MemRead = 1; addr = 0; ls = LW;
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (ld_cnt !== 32'd0 || st_cnt !== 32'd0) begin
            n_bad++; $display("FAIL cnt_rst got=%0d/%0d exp=0/0", ld_cnt, st_cnt);
        end
        @(posedge clk);
        #1;
        MemRead = 0; ls = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_fill;
        test_word_store_load;
        test_byte_merge;
        test_misaligned;
        test_clear_collision;
        test_alias_illegal;
        test_random;
        test_midcycle_reset;
`ifdef DM_ACCESS_CNT_EN
        test_counters;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
